// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - request/response and shared-SRAM signal bundle for sram_arbiter
interface sram_arbiter_if;
    logic        i_req;
    logic        i_wr;
    logic [3:0]  i_wstrb;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_wr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  i_req, i_wr, i_wstrb, i_addr, i_wdata,
        output i_addr_ok, i_data_ok, i_rdata,
        input  d_req, d_wr, d_wstrb, d_addr, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output i_req, i_wr, i_wstrb, i_addr, i_wdata,
        input  i_addr_ok, i_data_ok, i_rdata,
        output d_req, d_wr, d_wstrb, d_addr, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port (I/D) arbiter onto one single-port SRAM; SRAM_ARB_RR_EN selects round-robin
module sram_arbiter (
    input  logic          clk,
    input  logic          resetn,
    sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    state_t      state;
    logic        grant_i;
    logic        grant_d;
    logic        i_data_ok_q;
    logic        d_data_ok_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;
    logic [3:0]  cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

`ifdef SRAM_ARB_RR_EN
    // favour_d = 0 means the instruction port wins the next collision.
    logic favour_d;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (resetn) begin
            if (bus.i_req && bus.d_req) begin
                grant_d = favour_d;
                grant_i = ~favour_d;
            end else begin
                grant_i = bus.i_req;
                grant_d = bus.d_req;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            favour_d <= 1'b0;
        end else if (grant_i || grant_d) begin
            favour_d <= grant_i;
        end
    end
`else
    always_comb begin
        grant_d = resetn & bus.d_req;
        grant_i = resetn & bus.i_req & ~bus.d_req;
    end
`endif

    // Command mux: the address/data buses keep their last value while idle.
    always_comb begin
        cmd_we    = 4'b0000;
        cmd_addr  = addr_q;
        cmd_wdata = wdata_q;
        if (grant_d) begin
            cmd_we    = bus.d_wr ? bus.d_wstrb : 4'b0000;
            cmd_addr  = bus.d_addr;
            cmd_wdata = bus.d_wdata;
        end else if (grant_i) begin
            cmd_we    = bus.i_wr ? bus.i_wstrb : 4'b0000;
            cmd_addr  = bus.i_addr;
            cmd_wdata = bus.i_wdata;
        end
    end

    assign bus.i_addr_ok  = grant_i;
    assign bus.d_addr_ok  = grant_d;
    assign bus.sram_en    = grant_i | grant_d;
    assign bus.sram_we    = cmd_we;
    assign bus.sram_addr  = cmd_addr;
    assign bus.sram_wdata = cmd_wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            i_data_ok_q <= 1'b0;
            d_data_ok_q <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            i_rdata_q   <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            if (state == RESP_I) begin
                i_rdata_q <= bus.sram_rdata;
            end
            if (state == RESP_D) begin
                d_rdata_q <= bus.sram_rdata;
            end
            if (grant_i || grant_d) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end
            if (grant_d) begin
                state       <= RESP_D;
                i_data_ok_q <= 1'b0;
                d_data_ok_q <= 1'b1;
            end else if (grant_i) begin
                state       <= RESP_I;
                i_data_ok_q <= 1'b1;
                d_data_ok_q <= 1'b0;
            end else begin
                state       <= IDLE;
                i_data_ok_q <= 1'b0;
                d_data_ok_q <= 1'b0;
            end
        end
    end

    // Read data passes straight through in the response cycle, then is held.
    assign bus.i_data_ok = i_data_ok_q;
    assign bus.d_data_ok = d_data_ok_q;
    assign bus.i_rdata   = i_data_ok_q ? bus.sram_rdata : i_rdata_q;
    assign bus.d_rdata   = d_data_ok_q ? bus.sram_rdata : d_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized and directed bench for sram_arbiter against a transaction-level model
module tb_sram_arbiter;

    logic clk;
    logic resetn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if bus ();

    sram_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks;
    int errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int idx);
        if (idx == 4) return 32'hDEADBEEF;
        return 32'hC0DE0000 + 32'(idx) * 32'h00010101;
    endfunction

    // Single-port SRAM: registered read, byte-strobed write, read-before-write.
    logic [31:0] sram_mem [16];
    logic [31:0] sram_q;

    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= init_val(i);
        end else if (bus.sram_en) begin
            sram_q <= sram_mem[bus.sram_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (bus.sram_we[b]) sram_mem[bus.sram_addr[5:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
    end
    assign bus.sram_rdata = sram_q;

    // Transaction-level reference state.
    logic [31:0] gmem [16];
    int          m_resp;        // 0 none, 1 instruction, 2 data response due this cycle
    logic [31:0] m_resp_data;
    logic [31:0] m_last_addr;
    logic [31:0] m_last_wdata;
    logic [31:0] m_irdata;
    logic [31:0] m_drdata;
    logic        m_fav_d;
    logic        m_acc_i;
    logic        m_acc_d;

    task automatic model_cycle();
        int          winner;      // 0 none, 1 I, 2 D
        logic [3:0]  we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        wr;
        logic        idok;
        logic        ddok;
        if (!resetn) begin
            for (int i = 0; i < 16; i++) gmem[i] = init_val(i);
            m_resp = 0; m_last_addr = 0; m_last_wdata = 0;
            m_irdata = 0; m_drdata = 0; m_fav_d = 1'b0;
        end
        winner = 0;
        if (resetn) begin
            if (bus.i_req && !bus.d_req) winner = 1;
            else if (bus.d_req && !bus.i_req) winner = 2;
            else if (bus.d_req && bus.i_req) begin
`ifdef SRAM_ARB_RR_EN
                winner = m_fav_d ? 2 : 1;
`else
                winner = 2;
`endif
            end
        end
        a = m_last_addr; wd = m_last_wdata; wr = 1'b0; we = 4'b0000;
        if (winner == 1) begin
            a = bus.i_addr; wd = bus.i_wdata; wr = bus.i_wr; we = bus.i_wr ? bus.i_wstrb : 4'b0000;
        end else if (winner == 2) begin
            a = bus.d_addr; wd = bus.d_wdata; wr = bus.d_wr; we = bus.d_wr ? bus.d_wstrb : 4'b0000;
        end
        idok = (m_resp == 1);
        ddok = (m_resp == 2);
        check("i_addr_ok",  32'(bus.i_addr_ok), 32'(winner == 1));
        check("d_addr_ok",  32'(bus.d_addr_ok), 32'(winner == 2));
        check("sram_en",    32'(bus.sram_en),   32'(winner != 0));
        check("sram_we",    32'(bus.sram_we),   32'(we));
        check("sram_addr",  bus.sram_addr,      a);
        check("sram_wdata", bus.sram_wdata,     wd);
        check("i_data_ok",  32'(bus.i_data_ok), 32'(idok));
        check("d_data_ok",  32'(bus.d_data_ok), 32'(ddok));
        check("i_rdata",    bus.i_rdata,        idok ? m_resp_data : m_irdata);
        check("d_rdata",    bus.d_rdata,        ddok ? m_resp_data : m_drdata);
        if (idok) m_irdata = m_resp_data;
        if (ddok) m_drdata = m_resp_data;
        m_acc_i = (winner == 1);
        m_acc_d = (winner == 2);
        m_resp  = winner;
        if (winner != 0) begin
            m_resp_data  = gmem[a[5:2]];
            if (wr)
                for (int b = 0; b < 4; b++)
                    if (we[b]) gmem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
            m_last_addr  = a;
            m_last_wdata = wd;
            m_fav_d      = (winner == 1);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic drive_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ports();
        if (!bus.i_req || m_acc_i) begin
            bus.i_req   = ($urandom % 3) != 0;
            bus.i_wr    = $urandom % 2 == 1;
            bus.i_wstrb = 4'($urandom);
            bus.i_addr  = 32'h1C000000 + 32'(($urandom % 16) * 4);
            bus.i_wdata = $urandom;
        end
        if (!bus.d_req || m_acc_d) begin
            bus.d_req   = ($urandom % 3) != 0;
            bus.d_wr    = $urandom % 2 == 1;
            bus.d_wstrb = 4'($urandom);
            bus.d_addr  = 32'h1C000000 + 32'(($urandom % 16) * 4);
            bus.d_wdata = $urandom;
        end
    endtask

    int acnt;
    int dcnt;

    initial begin
        checks = 0; errors = 0;
        m_acc_i = 1'b0; m_acc_d = 1'b0; m_resp = 0; m_resp_data = 0;
        resetn = 1'b0;
        bus.i_req = 0; bus.i_wr = 0; bus.i_wstrb = 0; bus.i_addr = 0; bus.i_wdata = 0;
        bus.d_req = 0; bus.d_wr = 0; bus.d_wstrb = 0; bus.d_addr = 0; bus.d_wdata = 0;
        repeat (3) sample();

        // Single read, granted on the first edge after reset release.
        drive_wait();
        resetn = 1'b1;
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h1C000010;
        sample();
        check("rd_addr_ok", 32'(bus.d_addr_ok), 32'd1);
        check("rd_sram_en", 32'(bus.sram_en), 32'd1);
        check("rd_sram_we", 32'(bus.sram_we), 32'd0);
        drive_wait();
        bus.d_req = 0;
        sample();
        check("rd_data_ok", 32'(bus.d_data_ok), 32'd1);
        check("rd_rdata", bus.d_rdata, 32'hDEADBEEF);

`ifdef SRAM_ARB_RR_EN
        drive_wait();
        bus.i_req = 1; bus.i_wr = 0; bus.i_addr = 32'h1C000000;
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h1C000004;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("rr_i_grant", 32'(bus.i_addr_ok), 32'(k % 2 == 0));
            check("rr_d_grant", 32'(bus.d_addr_ok), 32'(k % 2 == 1));
            drive_wait();
            if (m_acc_i) bus.i_addr = bus.i_addr + 32'd8;
            if (m_acc_d) bus.d_addr = bus.d_addr + 32'd8;
        end
        bus.i_req = 0; bus.d_req = 0;
        sample();
`else
        drive_wait();
        bus.i_req = 1; bus.i_wr = 0; bus.i_addr = 32'h1C000000;
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h1C000004;
        sample();
        check("col_d_addr_ok_c0", 32'(bus.d_addr_ok), 32'd1);
        check("col_i_addr_ok_c0", 32'(bus.i_addr_ok), 32'd0);
        drive_wait();
        bus.d_req = 0;
        sample();
        check("col_i_addr_ok_c1", 32'(bus.i_addr_ok), 32'd1);
        check("col_d_data_ok_c1", 32'(bus.d_data_ok), 32'd1);
        drive_wait();
        bus.i_req = 0;
        sample();
        check("col_i_data_ok_c2", 32'(bus.i_data_ok), 32'd1);
`endif

        // Byte write, then read back the merged word.
        drive_wait();
        bus.d_req = 1; bus.d_wr = 1; bus.d_wstrb = 4'b0011;
        bus.d_addr = 32'h1C000020; bus.d_wdata = 32'h12345678;
        sample();
        check("bw_sram_we", 32'(bus.sram_we), 32'h3);
        check("bw_sram_wdata", bus.sram_wdata, 32'h12345678);
        drive_wait();
        bus.d_wr = 0;
        sample();
        check("bw_data_ok", 32'(bus.d_data_ok), 32'd1);
        drive_wait();
        bus.d_req = 0;
        sample();
        check("bw_readback", bus.d_rdata, (init_val(8) & 32'hFFFF0000) | 32'h00005678);

        // Instruction streaming: eight back-to-back reads with no bubbles.
        drive_wait();
        bus.i_req = 1; bus.i_wr = 0; bus.i_addr = 32'h1C000000;
        acnt = 0; dcnt = 0;
        for (int k = 0; k < 9; k++) begin
            sample();
            if (bus.i_addr_ok) acnt++;
            if (bus.i_data_ok) dcnt++;
            drive_wait();
            if (k < 7) bus.i_addr = bus.i_addr + 32'd4;
            else bus.i_req = 0;
        end
        check("stream_addr_ok_count", 32'(acnt), 32'd8);
        check("stream_data_ok_count", 32'(dcnt), 32'd8);

        // Reset in the cycle after a grant discards the access.
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 32'h1C000010;
        sample();
        drive_wait();
        resetn = 1'b0;
        bus.d_req = 0;
        sample();
        check("rst_no_data_ok", 32'(bus.d_data_ok), 32'd0);
        check("rst_sram_addr", bus.sram_addr, 32'd0);
        drive_wait();
        sample();
        drive_wait();
        resetn = 1'b1;
        bus.d_req = 1; bus.d_addr = 32'h1C000010;
        sample();
        check("rst_resume_addr_ok", 32'(bus.d_addr_ok), 32'd1);
        drive_wait();
        bus.d_req = 0;
        sample();
        check("rst_resume_rdata", bus.d_rdata, 32'hDEADBEEF);

        // Randomized traffic; requesters hold a request until it is accepted.
        m_acc_i = 1'b0; m_acc_d = 1'b0;
        for (int n = 0; n < 400; n++) begin
            drive_wait();
            rand_ports();
            sample();
        end
        drive_wait();
        bus.i_req = 0; bus.d_req = 0;
        repeat (2) sample();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 Port resetn, input, 1: asynchronous active-low reset.
REQ-003 Ports i_req / d_req, input, 1 each: instruction-port / data-port request valid.
REQ-004 Ports i_wr / d_wr, input, 1 each: 1 = write, 0 = read.
REQ-005 Ports i_wstrb / d_wstrb, input, 4 each: byte write strobes, used only when the wr bit is 1.
REQ-006 Ports i_addr / d_addr and i_wdata / d_wdata, input, 32 each: address and write data.
REQ-007 Ports i_addr_ok / d_addr_ok, output, 1 each: request accepted this cycle.
REQ-008 Ports i_data_ok / d_data_ok, output, 1 each: response valid this cycle.
REQ-009 Ports i_rdata / d_rdata, output, 32 each: read data, valid only with the matching data_ok.
REQ-010 Ports sram_en (1), sram_we (4), sram_addr (32), sram_wdata (32), all output: shared single-port SRAM command.
REQ-011 Port sram_rdata, input, 32: SRAM read data, one cycle after the sram_en cycle.

Function
REQ-012 The arbiter SHALL grant at most one requester per cycle.
- On grant: sram_en = 1, and sram_addr, sram_wdata and sram_we are taken from the winner.
- sram_we = wstrb for a write; 4'b0000 for a read.
- The winner's addr_ok = 1 in the same cycle (combinational).
REQ-013 Arbitration (default): fixed priority, data port over instruction port.
REQ-014 The block SHALL use a response FSM with states IDLE, RESP_I and RESP_D.
- The next state is RESP_I or RESP_D after an I or D grant, and IDLE when there is no grant.
REQ-015 In RESP_I: i_data_ok = 1 and i_rdata = sram_rdata. In RESP_D: d_data_ok = 1 and d_rdata = sram_rdata.
- Latency from addr_ok to data_ok is exactly 1 cycle, for reads and writes alike.
REQ-016 A new grant SHALL be allowed in the same cycle as a data_ok, so back-to-back accesses run at 1 per cycle.
REQ-017 Requesters cannot stall responses; data_ok is a single-cycle pulse and is never repeated.
REQ-018 When neither port requests:
- sram_en = 0, sram_we = 0, sram_addr and sram_wdata hold their last values.
- Both addr_ok outputs = 0.
REQ-019 When a request is not granted, it remains pending and the requester holds its signals stable until it sees addr_ok.
REQ-020 When rdata is not valid, i_rdata and d_rdata hold their last captured value.

Reset
REQ-021 While resetn = 0, all of the following SHALL hold:
- FSM = IDLE.
- sram_en = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.
- All addr_ok and data_ok outputs = 0; i_rdata = d_rdata = 0.
- Round-robin pointer (if compiled) = favour-instruction.
REQ-022 Reset asserted with an access outstanding SHALL discard that access; no data_ok is produced after reset is released.
REQ-023 The first grant is possible in the first rising edge after resetn deasserts.

Configuration
REQ-024 Macro SRAM_ARB_RR_EN: when defined, arbitration SHALL be two-way round-robin.
- A 1-bit pointer flips after each grant so that the other port is favoured next.
- If only one port requests, that port wins regardless of the pointer.
- When the macro is undefined, the pointer logic is absent and REQ-013 applies.

Verification
REQ-025 Single read: d_req=1, d_wr=0, d_addr=0x1C000010, SRAM returns 0xDEADBEEF.
- Cycle 0: d_addr_ok=1, sram_en=1, sram_we=0.
- Cycle 1: d_data_ok=1, d_rdata=0xDEADBEEF.
REQ-026 Collision: i_req and d_req both high in the same cycle, fixed priority.
- Cycle 0: d_addr_ok=1, i_addr_ok=0.
- Cycle 1: i_addr_ok=1 and d_data_ok=1.
- Cycle 2: i_data_ok=1.
REQ-027 Byte write: d_wr=1, d_wstrb=4'b0011, d_wdata=0x12345678.
- Cycle 0: sram_we=4'b0011, sram_wdata=0x12345678.
- Cycle 1: d_data_ok=1.
REQ-028 Streaming: i_req held high for 8 cycles with incrementing addresses.
- 8 consecutive addr_ok pulses.
- 8 consecutive data_ok pulses, each delayed by one cycle.
- No bubbles.
REQ-029 Reset mid-access: resetn dropped in the cycle after a grant.
- No data_ok.
- All outputs at their reset values.
- Normal operation resumes after release.
REQ-030 With SRAM_ARB_RR_EN defined: both ports request continuously for 4 cycles.
- Grant order I, D, I, D.
